// File: rtl/spi_slave_if.sv
// Byte-side handshake and SPI pin bundle for the SPI responder.
// The slave modport is the responder's view; master is the view of whoever drives it.
interface spi_slave_if;
    logic       i_TX_DV;
    logic [7:0] i_TX_Byte;
    logic       o_TX_Ready;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       o_TX_Underrun;
    logic       i_SPI_Clk;
    logic       i_SPI_CS_n;
    logic       i_SPI_MOSI;
    logic       o_SPI_MISO;
    logic       o_SPI_MISO_En;

    modport slave (
        input  i_TX_DV, i_TX_Byte, i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI,
        output o_TX_Ready, o_RX_DV, o_RX_Byte, o_TX_Underrun, o_SPI_MISO, o_SPI_MISO_En
    );

    modport master (
        output i_TX_DV, i_TX_Byte, i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI,
        input  o_TX_Ready, o_RX_DV, o_RX_Byte, o_TX_Underrun, o_SPI_MISO, o_SPI_MISO_En
    );
endinterface

// File: rtl/spi_slave.sv
// SPI responder: oversamples SCLK/CS_n/MOSI in the i_Clk domain and shifts bytes
// in and out in any of the four SPI modes, with a one-deep TX pending register.
module spi_slave #(
    parameter int unsigned SPI_MODE    = 0,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    spi_slave_if.slave bus
);
    localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_s, cs_s, mosi_s, sclk_q, cs_q;
    logic lead_edge, trail_edge, sample_edge, drive_edge, cs_fall, cs_rise;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] tx_sr, rx_byte_r, pend_byte, load_byte;
    logic       staged, tx_ready_r, rx_dv_r, underrun_r, miso_r, miso_en_r;
    logic       pop, capture;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_q    <= CPOL;
            cs_q      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.i_SPI_Clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.i_SPI_CS_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.i_SPI_MOSI};
            sclk_q    <= sclk_s;
            cs_q      <= cs_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign lead_edge   = (sclk_s != sclk_q) && (sclk_q == CPOL);
    assign trail_edge  = (sclk_s != sclk_q) && (sclk_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign drive_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_fall     = cs_q && !cs_s;
    assign cs_rise     = !cs_q && cs_s;

    // bit_cnt==7 on a drive edge marks a byte boundary in both phases: with CPHA=0 it
    // follows the 8th sample, with CPHA=1 it is the first leading edge of a byte.
    always_comb begin
        pop = 1'b0;
        if (state == IDLE)
            pop = !CPHA && cs_fall && !staged;
        else
            pop = !cs_rise && drive_edge && (bit_cnt == 3'd7);
    end

    assign load_byte = tx_ready_r ? IDLE_BYTE : pend_byte;
    assign capture   = bus.i_TX_DV && tx_ready_r;

    // A pop and a capture in the same cycle: the pop saw the old contents, capture wins.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tx_ready_r <= 1'b1;
            pend_byte  <= '0;
        end else begin
            if (pop)
                tx_ready_r <= 1'b1;
            if (capture) begin
                tx_ready_r <= 1'b0;
                pend_byte  <= bus.i_TX_Byte;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state      <= IDLE;
            bit_cnt    <= 3'd7;
            rx_sr      <= '0;
            tx_sr      <= '0;
            rx_byte_r  <= '0;
            staged     <= 1'b0;
            rx_dv_r    <= 1'b0;
            underrun_r <= 1'b0;
            miso_r     <= 1'b0;
            miso_en_r  <= 1'b0;
        end else begin
            rx_dv_r    <= 1'b0;
            underrun_r <= pop && tx_ready_r;
            case (state)
                IDLE: begin
                    miso_en_r <= 1'b0;
                    bit_cnt   <= 3'd7;
                    if (cs_fall) begin
                        state     <= ACTIVE;
                        miso_en_r <= 1'b1;
                        if (!CPHA) begin
                            // A byte staged by the previous frame is still whole in tx_sr.
                            if (staged) begin
                                staged <= 1'b0;
                                miso_r <= tx_sr[7];
                            end else begin
                                tx_sr  <= load_byte;
                                miso_r <= load_byte[7];
                            end
                        end
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state     <= IDLE;
                        miso_en_r <= 1'b0;
                        bit_cnt   <= 3'd7;
                    end else begin
                        if (sample_edge) begin
                            rx_sr <= {rx_sr[5:0], mosi_s};
                            if (bit_cnt == 3'd0) begin
                                rx_byte_r <= {rx_sr, mosi_s};
                                rx_dv_r   <= 1'b1;
                                bit_cnt   <= 3'd7;
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                            end
                            if (!CPHA && bit_cnt == 3'd7)
                                staged <= 1'b0;
                        end
                        if (drive_edge) begin
                            if (pop) begin
                                tx_sr  <= load_byte;
                                miso_r <= load_byte[7];
                                if (!CPHA)
                                    staged <= 1'b1;
                            end else begin
                                tx_sr  <= {tx_sr[6:0], 1'b0};
                                miso_r <= tx_sr[6];
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_TX_Ready    = tx_ready_r;
    assign bus.o_RX_DV       = rx_dv_r;
    assign bus.o_RX_Byte     = rx_byte_r;
    assign bus.o_TX_Underrun = underrun_r;
    assign bus.o_SPI_MISO    = miso_r;
    assign bus.o_SPI_MISO_En = miso_en_r;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode, a bit-banged master on the selected
// instance, and a scoreboard monitor matching RX bytes and sampled MISO bytes.
module tb_spi_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       sclk_base = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       tx_dv = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    int         sel = 0;

    logic [3:0]      ready, rx_dv, undr, miso, miso_en;
    logic [3:0][7:0] rx_byte;

    spi_slave_if ifc[4] ();

    for (genvar g = 0; g < 4; g++) begin : g_dut
        assign ifc[g].i_SPI_Clk  = sclk_base ^ (g >= 2);
        assign ifc[g].i_SPI_CS_n = (sel == g) ? cs_n : 1'b1;
        assign ifc[g].i_SPI_MOSI = mosi;
        assign ifc[g].i_TX_DV    = (sel == g) && tx_dv;
        assign ifc[g].i_TX_Byte  = tx_byte;
        assign ready[g]   = ifc[g].o_TX_Ready;
        assign rx_dv[g]   = ifc[g].o_RX_DV;
        assign rx_byte[g] = ifc[g].o_RX_Byte;
        assign undr[g]    = ifc[g].o_TX_Underrun;
        assign miso[g]    = ifc[g].o_SPI_MISO;
        assign miso_en[g] = ifc[g].o_SPI_MISO_En;
        spi_slave #(.SPI_MODE(g), .SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) u_dut (
            .i_Clk  (clk),
            .i_Rst_L(rst_n),
            .bus    (ifc[g])
        );
    end

    int n_cmp = 0;
    int n_err = 0;
    int undr_cnt = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_miso[$];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (mode %0d, t=%0t)", name, got, want, sel, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a byte.
    logic       prev_base = 1'b0;
    logic [7:0] miso_sr = 8'h00;
    int         nbits = 0;
    logic       en_ok = 1'b1;
    always @(negedge clk) begin
        logic [7:0] e;
        if (rx_dv[sel]) begin
            if (exp_rx.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rx_unexpected: got %h, no byte expected", rx_byte[sel]);
            end else begin
                e = exp_rx.pop_front();
                check("rx_byte", rx_byte[sel], e);
            end
        end
        for (int g = 0; g < 4; g++)
            if (g != sel && rx_dv[g]) begin
                n_cmp++; n_err++;
                $display("FAIL rx_idle_inst: instance %0d pulsed o_RX_DV, want none", g);
            end
        if (undr[sel]) undr_cnt++;
        if (cs_n) begin
            nbits = 0;
            en_ok = 1'b1;
        end else if (sclk_base != prev_base && sclk_base == !sel[0]) begin
            miso_sr = {miso_sr[6:0], miso[sel]};
            en_ok   = en_ok & miso_en[sel];
            nbits++;
            if (nbits == 8) begin
                if (exp_miso.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL miso_unexpected: got %h, no byte expected", miso_sr);
                end else begin
                    e = exp_miso.pop_front();
                    check("miso_byte", miso_sr, e);
                end
                check("miso_en", 8'(en_ok), 8'h01);
                nbits = 0;
                en_ok = 1'b1;
            end
        end
        prev_base = sclk_base;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // MOSI changes mid low-phase so it is stable around both SCLK edges.
    task automatic send_byte(input logic [7:0] b, input int nb);
        for (int i = 0; i < nb; i++) begin
            tick(3);
            mosi = b[7-i];
            tick(3);
            sclk_base = 1'b1;
            tick(6);
            sclk_base = 1'b0;
        end
    endtask

    task automatic cs_high();
        tick(6);
        cs_n = 1'b1;
        tick(8);
    endtask

    task automatic load(input logic [7:0] b);
        int t = 0;
        while (!ready[sel] && t < 1000) begin
            tick(1);
            t++;
        end
        if (t >= 1000) begin
            n_cmp++; n_err++;
            $display("FAIL load_timeout: o_TX_Ready stayed 0, want 1");
        end
        tx_byte = b;
        tx_dv = 1'b1;
        tick(1);
        tx_dv = 1'b0;
        check("ready_drop", 8'(ready[sel]), 8'h00);
    endtask

    task automatic do_reset();
        cs_n = 1'b1;
        sclk_base = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic check_reset_outs(input int g);
        check("rst_ready", 8'(ready[g]), 8'h01);
        check("rst_rx_dv", 8'(rx_dv[g]), 8'h00);
        check("rst_rx_byte", rx_byte[g], 8'h00);
        check("rst_underrun", 8'(undr[g]), 8'h00);
        check("rst_miso", 8'(miso[g]), 8'h00);
        check("rst_miso_en", 8'(miso_en[g]), 8'h00);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0;
        logic [7:0] b81_u[4];
        b81_u = '{8'd0, 8'd0, 8'd1, 8'd0};

        // Reset state on every instance.
        tick(3);
        for (int g = 0; g < 4; g++) check_reset_outs(g);
        rst_n = 1'b1;
        tick(4);

        // Mode 0 single byte; the trailing edge after the 8th sample pops an empty register.
        sel = 0;
        load(8'hA5);
        exp_miso.push_back(8'hA5); exp_rx.push_back(8'h3C);
        u0 = undr_cnt;
        cs_n = 1'b0;
        send_byte(8'h3C, 8);
        cs_high();
        check("underrun_m0", 8'(undr_cnt - u0), 8'd1);
        check("ready_after_m0", 8'(ready[sel]), 8'h01);

        // Modes 1..3, TX 81 / MOSI 7E.
        for (int m = 1; m < 4; m++) begin
            do_reset();
            sel = m;
            load(8'h81);
            exp_miso.push_back(8'h81); exp_rx.push_back(8'h7E);
            u0 = undr_cnt;
            cs_n = 1'b0;
            send_byte(8'h7E, 8);
            cs_high();
            check("underrun_mode", 8'(undr_cnt - u0), b81_u[m]);
            check("ready_after_mode", 8'(ready[sel]), 8'h01);
        end

        // Mode 1, 3-byte frame; third load underruns.
        do_reset();
        sel = 1;
        load(8'h11);
        exp_miso.push_back(8'h11); exp_miso.push_back(8'h22); exp_miso.push_back(8'hFF);
        exp_rx.push_back(8'hA1); exp_rx.push_back(8'hB2); exp_rx.push_back(8'hC3);
        u0 = undr_cnt;
        cs_n = 1'b0;
        fork
            begin send_byte(8'hA1, 8); send_byte(8'hB2, 8); send_byte(8'hC3, 8); end
            load(8'h22);
        join
        cs_high();
        check("underrun_3byte", 8'(undr_cnt - u0), 8'd1);

        // Mode 0, CS rises after 5 bits; no RX byte, next frame starts clean.
        do_reset();
        sel = 0;
        load(8'h5A);
        u0 = undr_cnt;
        cs_n = 1'b0;
        send_byte(8'hB0, 5);
        cs_high();
        check("rx_after_abort", 8'(exp_rx.size()), 8'd0);
        load(8'h96);
        exp_miso.push_back(8'h96); exp_rx.push_back(8'hC3);
        cs_n = 1'b0;
        send_byte(8'hC3, 8);
        cs_high();
        check("underrun_abort", 8'(undr_cnt - u0), 8'd1);

        // Mode 0, 55 popped at the end of byte 2 and staged across CS.
        do_reset();
        sel = 0;
        load(8'hA0);
        exp_miso.push_back(8'hA0); exp_miso.push_back(8'hB0);
        exp_rx.push_back(8'h12); exp_rx.push_back(8'h34);
        u0 = undr_cnt;
        cs_n = 1'b0;
        fork
            begin send_byte(8'h12, 8); send_byte(8'h34, 8); end
            begin load(8'hB0); load(8'h55); end
        join
        cs_high();
        check("underrun_stage1", 8'(undr_cnt - u0), 8'd0);
        load(8'h77);
        exp_miso.push_back(8'h55); exp_rx.push_back(8'h56);
        cs_n = 1'b0;
        send_byte(8'h56, 8);
        cs_high();
        check("underrun_stage2", 8'(undr_cnt - u0), 8'd0);
        check("ready_after_stage", 8'(ready[sel]), 8'h01);

        // Asynchronous reset mid-byte (77 staged, C7 pending, RX_Byte=56).
        load(8'hC7);
        cs_n = 1'b0;
        send_byte(8'hAA, 4);
        check("pre_rst_miso_en", 8'(miso_en[sel]), 8'h01);
        check("pre_rst_ready", 8'(ready[sel]), 8'h00);
        #2 rst_n = 1'b0;
        #1 check_reset_outs(sel);
        cs_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        load(8'h3E);
        exp_miso.push_back(8'h3E); exp_rx.push_back(8'h99);
        u0 = undr_cnt;
        cs_n = 1'b0;
        send_byte(8'h99, 8);
        cs_high();
        check("underrun_post_rst", 8'(undr_cnt - u0), 8'd1);

        tick(10);
        check("rx_left", 8'(exp_rx.size()), 8'd0);
        check("miso_left", 8'(exp_miso.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI peripheral-side (responder) engine. It is the counterpart of the team's SPI master and serves as the target end for loopback and board-to-board links.
- Oversamples the external SCLK, CS_n and MOSI pins in the i_Clk domain. Delivers each received byte with a one-cycle valid pulse.
- Shifts out a byte supplied over a ready/valid handshake. Supports all four SPI modes and back-to-back multi-byte frames under one CS assertion.

Parameters:
SPI_MODE, 0, 0..3; CPOL = (mode 2 or 3), CPHA = (mode 1 or 3)
SYNC_STAGES, 2, flops per input synchronizer (min 2)
IDLE_BYTE, 8'hFF, byte shifted out when no TX byte is pending

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  reset, asynchronous assert, active-low
i_TX_DV  in  1  TX byte valid; accepted only while o_TX_Ready=1
i_TX_Byte  in  8  byte to send on MISO, MSB first
o_TX_Ready  out  1  pending-TX register empty
o_RX_DV  out  1  one-cycle pulse: o_RX_Byte holds a new byte
o_RX_Byte  out  8  last received byte, MSB first
o_TX_Underrun  out  1  one-cycle pulse: IDLE_BYTE substituted for a missing TX byte
i_SPI_Clk  in  1  SCLK from master (asynchronous)
i_SPI_CS_n  in  1  chip select, active-low (asynchronous)
i_SPI_MOSI  in  1  master-out data (asynchronous)
o_SPI_MISO  out  1  slave-out data
o_SPI_MISO_En  out  1  MISO output enable (for an external tri-state)

Behaviour:
- Reset (i_Rst_L=0, asynchronous): o_TX_Ready=1, o_RX_DV=0, o_RX_Byte=0, o_TX_Underrun=0, o_SPI_MISO=0, o_SPI_MISO_En=0. Synchronizers are cleared to SCLK=CPOL, CS_n=1, MOSI=0; the pending and staged flags are cleared; state=IDLE.
- Synchronization: SCLK, CS_n and MOSI each pass through SYNC_STAGES flops. All edge detection uses the synchronized value versus its previous-cycle copy.
- Edge definitions:
  - Leading edge: SCLK transition away from CPOL.
  - Trailing edge: SCLK transition back to CPOL.
  - Sample edge: leading if CPHA=0, trailing if CPHA=1.
  - Drive edge: the other one.
- Timing requirement: each SCLK half-period must be at least SYNC_STAGES+2 i_Clk cycles. Behaviour is undefined otherwise.
- TX handshake: while o_TX_Ready=1, i_TX_DV=1 captures i_TX_Byte into the pending register. o_TX_Ready drops on the next cycle. i_TX_DV is ignored while o_TX_Ready=0.
- Pop: a byte load consumes the pending byte and o_TX_Ready rises the next cycle. If no byte is pending, the load uses IDLE_BYTE and pulses o_TX_Underrun for one cycle.
  - If the pop and an i_TX_DV capture fall in the same cycle, the pop consumes the old byte and the new byte is captured.
- FSM:
  - IDLE: CS_n synced high, MISO_En=0, bit counters=7. A synced CS_n fall moves to ACTIVE.
  - ACTIVE: MISO_En=1. A synced CS_n rise returns to IDLE.
- Loads with CPHA=0:
  - On entry to ACTIVE, load the staged byte if the staged flag is set (clear the flag, no pop), else pop. Drive bit7.
  - Each trailing edge drives the next bit.
  - The trailing edge after the 8th sample loads the next byte (pop) and sets the staged flag; the flag is cleared at that byte's first sample edge.
- Loads with CPHA=1: each leading edge drives the next bit. The first leading edge of every byte loads (pop) and drives bit7.
- RX:
  - Each sample edge shifts the synced MOSI into the RX shift register, MSB first, and decrements the counter.
  - On the 8th sample, o_RX_Byte updates and o_RX_DV pulses on the next i_Clk. Latency is 1 cycle after the synced sample edge, i.e. SYNC_STAGES+1 cycles after the pin edge.
  - The counter wraps to 7 for back-to-back bytes.
- CS rise mid-byte: the partial RX byte is discarded (no o_RX_DV) and the counters reset to 7. The pending byte is retained. A staged CPHA=0 byte is retained and sent at the next CS assertion.
- Edges while IDLE: SCLK edges are ignored, and MOSI and MISO activity has no effect.
- o_SPI_MISO keeps its last value while IDLE; only MISO_En gates it.

Test Plan:
- Mode 0, load 8'hA5 then assert CS and clock MOSI=8'h3C → MISO shows 1010_0101, o_RX_Byte=8'h3C, o_RX_DV pulses exactly once, o_TX_Ready returns to 1.
- Modes 1, 2 and 3, each with TX 8'h81 and MOSI 8'h7E → correct bits sampled and driven on the proper edges; RX byte is 8'h7E in every mode.
- 3-byte frame under one CS with TX bytes 8'h11 and 8'h22 loaded, then nothing → MISO 8'h11, 8'h22, 8'hFF; o_TX_Underrun pulses once at the third load; three o_RX_DV pulses.
- CS deasserted after 5 bits → no o_RX_DV. On the next full frame with MOSI=8'hC3, RX=8'hC3 and the next TX byte is sent from bit7.
- Mode 0, two-byte frame with 8'h55 pending after the first byte; CS rises right after byte 2 → 8'h55 is staged. The next frame transmits 8'h55 with no underrun.
- Assert i_Rst_L=0 mid-byte → all outputs take their reset values immediately (asynchronously); the next frame after release works normally.
